bsg_mul_iterative_booth_gen: RTL

//  Parametrised iterative radix-4 Booth multiplier: width_p x width_p -> 2*width_p product, stride_p multiplier bits retired/cycle.
//  Per-operand signedness (uu/su/us/ss, incl. mulhsu), optional early termination, in-flight cancel.

---
 rtl/bsg_mul_iterative_booth_gen_if.sv | 31 +++
 rtl/bsg_mul_iterative_booth_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bsg_mul_iterative_booth_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : bsg_mul_iterative_booth_gen_if
// Brief   : Request/result handshake bundle for the iterative Booth multiplier.
// Revision: 1.0
// ============================================================================
interface bsg_mul_iterative_booth_gen_if #(
  parameter int width_p = 64
);
  logic                   v_i;
  logic                   ready_o;
  logic [width_p-1:0]     opA_i;
  logic [width_p-1:0]     opB_i;
  logic                   opA_signed_i;
  logic                   opB_signed_i;
  logic                   cancel_i;
  logic                   v_o;
  logic [2*width_p-1:0]   result_o;
  logic                   yumi_i;

  modport master (
    output v_i, opA_i, opB_i, opA_signed_i, opB_signed_i, cancel_i, yumi_i,
    input  ready_o, v_o, result_o
  );

  modport slave (
    input  v_i, opA_i, opB_i, opA_signed_i, opB_signed_i, cancel_i, yumi_i,
    output ready_o, v_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_mul_iterative_booth_gen.sv
`default_nettype none
// ============================================================================
// Module  : bsg_mul_iterative_booth_gen
// Brief   : Iterative radix-4 Booth multiplier, carry-save accumulate + final CPA.
// Revision: 1.0
// ============================================================================
module bsg_mul_iterative_booth_gen #(
  parameter int width_p     = 64,
  parameter int stride_p    = 16,
  parameter int early_out_p = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bsg_mul_iterative_booth_gen_if.slave bus
);

  localparam int C_ACC_W  = 2*width_p + stride_p + 4;
  localparam int C_B_W    = width_p + 3;
  localparam int C_DIGITS = stride_p / 2;
  localparam int C_K_MAX  = (width_p + 2 + stride_p - 1) / stride_p;
  localparam int C_CNT_W  = $clog2(C_K_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CPA  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q,  state_d;
  logic [C_ACC_W-1:0]     a_q,      a_d;
  logic [C_ACC_W-1:0]     sum_q,    sum_d;
  logic [C_ACC_W-1:0]     carry_q,  carry_d;
  logic [C_B_W-1:0]       b_q,      b_d;
  logic [C_CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*width_p-1:0]   result_q, result_d;

  logic [C_ACC_W-1:0]     w_csa_s, w_csa_c, w_nxt_s, w_pp, w_mag, w_neg;
  logic [2:0]             w_trip;
  logic                   w_one, w_two, w_dneg;
  logic [C_B_W-1:0]       w_b_shift;
  logic                   w_rem_zero, w_last;

  // b_q[0] is the Booth overlap bit b[-1]; a_q carries the multiplicand
  // pre-shifted to the weight of the digits retired this cycle.
  always_comb begin
    w_csa_s = sum_q;
    w_csa_c = carry_q;
    w_neg   = '0;
    w_trip  = '0;
    w_one   = 1'b0;
    w_two   = 1'b0;
    w_dneg  = 1'b0;
    w_mag   = '0;
    w_pp    = '0;
    w_nxt_s = '0;
    for (int j = 0; j < C_DIGITS; j++) begin
      w_trip   = b_q[2*j +: 3];
      w_one    = w_trip[1] ^ w_trip[0];
      w_two    = (w_trip[2] & ~w_trip[1] & ~w_trip[0]) | (~w_trip[2] & w_trip[1] & w_trip[0]);
      w_dneg   = w_trip[2] & ~(w_trip[1] & w_trip[0]);
      w_mag    = w_two ? (a_q << 1) : (w_one ? a_q : '0);
      w_pp     = (w_dneg ? ~w_mag : w_mag) << (2*j);
      w_neg[2*j] = w_dneg;
      w_nxt_s  = w_csa_s ^ w_csa_c ^ w_pp;
      w_csa_c  = ((w_csa_s & w_csa_c) | (w_csa_s & w_pp) | (w_csa_c & w_pp)) << 1;
      w_csa_s  = w_nxt_s;
    end
    // The +1 of every one's-complement negation enters as one extra row.
    w_nxt_s = w_csa_s ^ w_csa_c ^ w_neg;
    w_csa_c = ((w_csa_s & w_csa_c) | (w_csa_s & w_neg) | (w_csa_c & w_neg)) << 1;
    w_csa_s = w_nxt_s;
  end

  assign w_b_shift  = $signed(b_q) >>> stride_p;
  assign w_rem_zero = (w_b_shift == '0) || (&w_b_shift);
  assign w_last     = (cnt_q == C_CNT_W'(C_K_MAX - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.v_i) begin
          a_d     = {{(C_ACC_W-width_p){bus.opA_signed_i & bus.opA_i[width_p-1]}}, bus.opA_i};
          b_d     = {{2{bus.opB_signed_i & bus.opB_i[width_p-1]}}, bus.opB_i, 1'b0};
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.cancel_i) begin
          state_d = S_IDLE;
        end else begin
          sum_d   = w_csa_s;
          carry_d = w_csa_c;
          a_d     = a_q << stride_p;
          b_d     = w_b_shift;
          cnt_d   = cnt_q + C_CNT_W'(1);
          if (w_last || ((early_out_p != 0) && w_rem_zero)) begin
            state_d = S_CPA;
          end
        end
      end
      S_CPA: begin
        if (bus.cancel_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = sum_q[2*width_p-1:0] + carry_q[2*width_p-1:0];
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.cancel_i || bus.yumi_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.v_o      = (state_q == S_DONE);
  assign bus.result_o = result_q;

endmodule
`default_nettype wire
